// File: rtl/issue_unit_pkg.sv
// Shared types and default latencies for the issue unit and its CDB reservation register.
package issue_unit_pkg;

  typedef enum logic [1:0] {
    EU_INT  = 2'd0,
    EU_MULT = 2'd1,
    EU_DIV  = 2'd2,
    EU_MEM  = 2'd3
  } exec_unit_e;

  typedef struct packed {
    logic       valid;
    exec_unit_e unit;
  } rsv_entry_t;

  localparam int INT_LAT_DEF  = 1;
  localparam int MEM_LAT_DEF  = 2;
  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 7;

endpackage

// File: rtl/issue_unit_cdb_reservation_reg.sv
// CDB reservation shift register: entry k says which unit owns the CDB k cycles from now.
module cdb_reservation_reg
  import issue_unit_pkg::*;
#(
  parameter int DEPTH    = DIV_LAT_DEF,
  parameter int INT_LAT  = INT_LAT_DEF,
  parameter int MEM_LAT  = MEM_LAT_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] wr_i,
  output logic [3:0] free_o,
  output rsv_entry_t head_o
);

  rsv_entry_t     rsv_q [DEPTH];
  rsv_entry_t     rsv_d [DEPTH];
  logic [DEPTH:0] vld_ext;

  always_comb begin
    for (int k = 0; k < DEPTH - 1; k++) rsv_d[k] = rsv_q[k+1];
    rsv_d[DEPTH-1] = '0;
    // A grant lands one slot below its latency because the write happens alongside the shift.
    if (wr_i[EU_INT])  rsv_d[INT_LAT-1]  = rsv_entry_t'{valid: 1'b1, unit: EU_INT};
    if (wr_i[EU_MEM])  rsv_d[MEM_LAT-1]  = rsv_entry_t'{valid: 1'b1, unit: EU_MEM};
    if (wr_i[EU_MULT]) rsv_d[MULT_LAT-1] = rsv_entry_t'{valid: 1'b1, unit: EU_MULT};
    if (wr_i[EU_DIV])  rsv_d[DIV_LAT-1]  = rsv_entry_t'{valid: 1'b1, unit: EU_DIV};
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (!rst) rsv_q[k] <= '0;
      else      rsv_q[k] <= rsv_d[k];
    end
  end

  // Slot DEPTH lies past the end of the register and always reads as free.
  for (genvar k = 0; k < DEPTH; k++) begin : g_vld
    assign vld_ext[k] = rsv_q[k].valid;
  end
  assign vld_ext[DEPTH] = 1'b0;

  assign free_o[EU_INT]  = ~vld_ext[INT_LAT];
  assign free_o[EU_MEM]  = ~vld_ext[MEM_LAT];
  assign free_o[EU_MULT] = ~vld_ext[MULT_LAT];
  assign free_o[EU_DIV]  = ~vld_ext[DIV_LAT];
  assign head_o          = rsv_q[0];

endmodule

// File: rtl/issue_unit.sv
// Issue-queue responder: grants ready queues whose CDB slot is free and tracks the divider.
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int INT_LAT  = INT_LAT_DEF,
  parameter int MEM_LAT  = MEM_LAT_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       int_ready,
  input  logic       mult_ready,
  input  logic       div_ready,
  input  logic       mem_ready,
  output logic       int_done,
  output logic       mult_done,
  output logic       div_done,
  output logic       mem_done,
  output logic       div_busy,
  output logic       cdb_sel_valid,
  output logic [1:0] cdb_sel_unit
);

  localparam int CNT_W = $clog2(DIV_LAT);

  logic [3:0]       free;
  logic [3:0]       grant;
  rsv_entry_t       head;
  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;

  always_comb begin
    grant          = '0;
    grant[EU_INT]  = rst & int_ready  & free[EU_INT];
    grant[EU_MEM]  = rst & mem_ready  & free[EU_MEM];
    grant[EU_MULT] = rst & mult_ready & free[EU_MULT];
    grant[EU_DIV]  = rst & div_ready  & free[EU_DIV] & (div_cnt_q == '0);
  end

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (grant[EU_DIV])         div_cnt_d = CNT_W'(DIV_LAT - 1);
    else if (div_cnt_q != '0)  div_cnt_d = div_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) div_cnt_q <= '0;
    else      div_cnt_q <= div_cnt_d;
  end

  cdb_reservation_reg #(
    .DEPTH   (DIV_LAT),
    .INT_LAT (INT_LAT),
    .MEM_LAT (MEM_LAT),
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_rsv (
    .clk   (clk),
    .rst   (rst),
    .wr_i  (grant),
    .free_o(free),
    .head_o(head)
  );

  assign int_done      = grant[EU_INT];
  assign mult_done     = grant[EU_MULT];
  assign div_done      = grant[EU_DIV];
  assign mem_done      = grant[EU_MEM];
  assign div_busy      = rst & (div_cnt_q != '0);
  assign cdb_sel_valid = rst & head.valid;
  assign cdb_sel_unit  = rst ? head.unit : 2'd0;

endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: grants, CDB owner timing, divider occupancy and reset flush.
module tb_issue_unit;

  logic       clk;
  logic       rst;
  logic       int_ready, mult_ready, div_ready, mem_ready;
  logic       int_done, mult_done, div_done, mem_done;
  logic       div_busy, cdb_sel_valid;
  logic [1:0] cdb_sel_unit;
  logic [3:0] dn;

  int checks   = 0;
  int failures = 0;

  issue_unit dut (
    .clk          (clk),
    .rst          (rst),
    .int_ready    (int_ready),
    .mult_ready   (mult_ready),
    .div_ready    (div_ready),
    .mem_ready    (mem_ready),
    .int_done     (int_done),
    .mult_done    (mult_done),
    .div_done     (div_done),
    .mem_done     (mem_done),
    .div_busy     (div_busy),
    .cdb_sel_valid(cdb_sel_valid),
    .cdb_sel_unit (cdb_sel_unit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {int, mult, div, mem}
  assign dn = {int_done, mult_done, div_done, mem_done};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic [3:0] r);
    {int_ready, mult_ready, div_ready, mem_ready} = r;
  endtask

  // Owner expected on the CDB k cycles after the all-units grant (k = 1..7); 4 means idle.
  int owner_tab [1:7] = '{0, 3, 4, 1, 4, 4, 2};

  initial begin
    rst = 1'b0;
    set_ready(4'b1111);

    // Reset held with every queue ready
    repeat (2) begin
      @(negedge clk);
      chk("rst_done", 32'(dn), 32'h0);
      chk("rst_cdb_valid", 32'(cdb_sel_valid), 32'h0);
      chk("rst_cdb_unit", 32'(cdb_sel_unit), 32'h0);
      chk("rst_div_busy", 32'(div_busy), 32'h0);
    end

    // t0: first cycle after release grants all four units
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t0_all_done", 32'(dn), 32'hF);
    for (int k = 1; k <= 7; k++) begin
      tick();
      set_ready(4'b0000);
      @(negedge clk);
      if (owner_tab[k] == 4) begin
        chk($sformatf("owner_idle_t%0d", k), 32'(cdb_sel_valid), 32'h0);
      end else begin
        chk($sformatf("owner_valid_t%0d", k), 32'(cdb_sel_valid), 32'h1);
        chk($sformatf("owner_unit_t%0d", k), 32'(cdb_sel_unit), 32'(owner_tab[k]));
      end
      chk($sformatf("div_busy_t%0d", k), 32'(div_busy), (k <= 6) ? 32'h1 : 32'h0);
    end

    // INT alone streams back-to-back
    for (int i = 0; i < 10; i++) begin
      tick();
      set_ready(4'b1000);
      @(negedge clk);
      chk($sformatf("int_stream_done_%0d", i), 32'(dn), 32'h8);
      if (i > 0) begin
        chk($sformatf("int_stream_valid_%0d", i), 32'(cdb_sel_valid), 32'h1);
        chk($sformatf("int_stream_unit_%0d", i), 32'(cdb_sel_unit), 32'h0);
      end
    end

    // MULT at t blocks INT at t+3
    tick();
    set_ready(4'b0100);
    @(negedge clk);
    chk("mult_grant", 32'(dn), 32'h4);
    tick();
    set_ready(4'b0000);
    tick();
    tick();
    set_ready(4'b1000);
    @(negedge clk);
    chk("int_blocked_t3", 32'(int_done), 32'h0);
    tick();
    @(negedge clk);
    chk("int_grant_t4", 32'(int_done), 32'h1);
    chk("mult_cdb_valid_t4", 32'(cdb_sel_valid), 32'h1);
    chk("mult_cdb_unit_t4", 32'(cdb_sel_unit), 32'h1);
    tick();
    set_ready(4'b0000);
    @(negedge clk);
    chk("int_cdb_valid_t5", 32'(cdb_sel_valid), 32'h1);
    chk("int_cdb_unit_t5", 32'(cdb_sel_unit), 32'h0);

    // Divider held ready: grants DIV_LAT apart
    for (int i = 0; i <= 8; i++) begin
      tick();
      set_ready(4'b0010);
      @(negedge clk);
      chk($sformatf("div_hold_done_%0d", i), 32'(div_done), (i == 0 || i == 7) ? 32'h1 : 32'h0);
      chk($sformatf("div_hold_busy_%0d", i), 32'(div_busy), (i == 0 || i == 7) ? 32'h0 : 32'h1);
      if (i == 7) begin
        chk("div_cdb_valid_t7", 32'(cdb_sel_valid), 32'h1);
        chk("div_cdb_unit_t7", 32'(cdb_sel_unit), 32'h2);
      end
    end

    // Drain the in-flight divide before the reset scenario
    tick();
    set_ready(4'b0000);
    repeat (8) tick();

    // DIV at t, reset at t+2, new DIV right after release
    set_ready(4'b0010);
    @(negedge clk);
    chk("div_pre_rst_done", 32'(div_done), 32'h1);
    tick();
    set_ready(4'b0000);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_done", 32'(dn), 32'h0);
    chk("mid_rst_cdb_valid", 32'(cdb_sel_valid), 32'h0);
    chk("mid_rst_cdb_unit", 32'(cdb_sel_unit), 32'h0);
    chk("mid_rst_busy", 32'(div_busy), 32'h0);
    tick();
    rst = 1'b1;
    set_ready(4'b0010);
    @(negedge clk);
    chk("post_rst_div_done", 32'(div_done), 32'h1);
    chk("post_rst_busy", 32'(div_busy), 32'h0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      set_ready(4'b0000);
      @(negedge clk);
      chk($sformatf("post_rst_cdb_valid_%0d", k), 32'(cdb_sel_valid), (k == 7) ? 32'h1 : 32'h0);
      if (k == 7) chk("post_rst_cdb_unit_7", 32'(cdb_sel_unit), 32'h2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
